cic_decimator: RTL and testbench

- Multi-channel (I/Q) CIC decimation filter that consumes the mixer's baseband stream.
- Lowers the sample rate by a runtime ratio ahead of the channel FIR.
- Valid-only stream: no backpressure, same as the mixer output.
- Hogenauer structure: N pipelined integrators at the input rate, a decimation counter, N combs at the output rate, and a final truncation/rounding stage down to DATA_WIDTH.

---
 rtl/cic_decimator.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_cic_decimator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// Multi-channel (I/Q) Hogenauer CIC decimation filter placed between the mixer
// and the channel FIR. Valid-only stream, no backpressure.
//
// Structure, per channel:
//   - STAGES pipelined integrators running at the input rate. Stage k adds
//     the value stage k-1 held before the current sample, which delays the
//     response by STAGES-1 samples versus a non-pipelined CIC.
//   - One decimation counter shared by all channels. On the wrap sample a
//     strobe enters the pipeline. The next clock captures the last integrator.
//   - STAGES registered combs (differential delay DIFF_DELAY). Each comb
//     advances only when the strobe reaches it, so several decimated samples
//     can be in flight together (R=1 gives one output per accepted input).
//   - Output stage: top DATA_WIDTH bits of the accumulator (floor).
//
// Optional build macro CIC_ROUND_EN:
//   When defined, the output stage adds half an LSB (round half up) and
//   saturates to the DATA_WIDTH signed range. This adds one register stage.
//   Latency from the edge that accepts the wrap sample to tvalid_o is then
//   STAGES+3 clocks. Without the macro it is STAGES+2 clocks.
//
// Ports:
//   clk_i     in   clock
//   rstn_i    in   asynchronous active-low reset
//   en_i      in   global enable; low freezes all state and drops inputs
//   decim_i   in   decimation ratio R (1..MAX_DECIM); 0 or >MAX_DECIM -> MAX_DECIM
//   tvalid_i  in   input sample valid
//   tdata_i   in   signed input samples, channel 0 = I
//   tvalid_o  out  single-cycle decimated sample valid
//   tdata_o   out  signed decimated samples, held between pulses
// -----------------------------------------------------------------------------
module cic_decimator #(
  parameter int IQ_NUM     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 3,
  parameter int MAX_DECIM  = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              en_i,
  input  logic [$clog2(MAX_DECIM):0]        decim_i,
  input  logic                              tvalid_i,
  input  logic [IQ_NUM-1:0][DATA_WIDTH-1:0] tdata_i,
  output logic                              tvalid_o,
  output logic [IQ_NUM-1:0][DATA_WIDTH-1:0] tdata_o
);

  localparam int ACC_WIDTH = DATA_WIDTH + STAGES * $clog2(MAX_DECIM * DIFF_DELAY);
  localparam int RW        = $clog2(MAX_DECIM) + 1;
  localparam int CW        = (MAX_DECIM > 1) ? $clog2(MAX_DECIM) : 1;

`ifdef CIC_ROUND_EN
  localparam int PIPE = STAGES + 3;
`else
  localparam int PIPE = STAGES + 2;
`endif

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Illegal ratios (0 or above MAX_DECIM) fall back to MAX_DECIM.
  function automatic logic [RW-1:0] sanitize_ratio(input logic [RW-1:0] r);
    logic [RW-1:0] res;
    if ((r == {RW{1'b0}}) || (r > RW'(MAX_DECIM))) begin
      res = RW'(MAX_DECIM);
    end else begin
      res = r;
    end
    return res;
  endfunction

  // Sign-extend one input sample to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return ACC_WIDTH'($signed(x));
  endfunction

`ifdef CIC_ROUND_EN
  localparam logic [ACC_WIDTH:0] HALF_LSB =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (ACC_WIDTH - DATA_WIDTH - 1);

  // Round half up on the top DATA_WIDTH bits, then saturate. The sum is one
  // bit wider so a carry out of the top is visible as a sign disagreement.
  function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [ACC_WIDTH-1:0] acc);
    logic [ACC_WIDTH:0]    sum;
    logic [DATA_WIDTH:0]   top;
    logic [DATA_WIDTH-1:0] res;
    sum = {acc[ACC_WIDTH-1], acc} + HALF_LSB;
    top = sum[ACC_WIDTH -: (DATA_WIDTH + 1)];
    if (top[DATA_WIDTH] != top[DATA_WIDTH-1]) begin
      res = top[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      res = top[DATA_WIDTH-1:0];
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Decimation control
  // ---------------------------------------------------------------------------
  logic [RW-1:0] r_ratio;
  logic          r_ratio_ld;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] w_ratio;
  logic          w_accept;
  logic          w_wrap;

  // Until the ratio has been latched, decim_i itself governs the first period.
  always_comb begin
    w_ratio  = r_ratio_ld ? r_ratio : sanitize_ratio(decim_i);
    w_accept = tvalid_i & en_i;
    w_wrap   = w_accept & (RW'(r_cnt) == (w_ratio - RW'(1)));
  end

  // Ratio latch and sample counter. A new ratio is latched only on the first
  // enabled cycle after reset and at each wrap, so a period never changes
  // length part way through.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ratio    <= {RW{1'b0}};
      r_ratio_ld <= 1'b0;
      r_cnt      <= {CW{1'b0}};
    end else if (en_i) begin
      if (!r_ratio_ld || w_wrap) begin
        r_ratio <= sanitize_ratio(decim_i);
      end
      r_ratio_ld <= 1'b1;
      if (w_wrap) begin
        r_cnt <= {CW{1'b0}};
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe pipeline: bit 0 marks the wrap sample; bit k+1 marks valid data at
  // the input of comb k; bit PIPE-1 loads the output register.
  // ---------------------------------------------------------------------------
  logic [PIPE-1:0] r_stb;

  // Advance strobes once per enabled clock; reset flushes anything in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stb <= {PIPE{1'b0}};
    end else if (en_i) begin
      r_stb <= {r_stb[PIPE-2:0], w_wrap};
    end
  end

  // ---------------------------------------------------------------------------
  // Integrators (input rate, modular arithmetic, never saturate)
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] r_int [IQ_NUM][STAGES];

  // Pipelined integrator chain: each stage adds the previous stage's old value.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          r_int[c][k] <= {ACC_WIDTH{1'b0}};
        end
      end
    end else if (w_accept) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        r_int[c][0] <= r_int[c][0] + sext(tdata_i[c]);
        for (int k = 1; k < STAGES; k++) begin
          r_int[c][k] <= r_int[c][k] + r_int[c][k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture register and comb chain (output rate)
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] r_cap     [IQ_NUM];
  logic [ACC_WIDTH-1:0] r_comb    [IQ_NUM][STAGES];
  logic [ACC_WIDTH-1:0] r_dly     [IQ_NUM][STAGES][DIFF_DELAY];
  logic [ACC_WIDTH-1:0] w_comb_in [IQ_NUM][STAGES];

  // Capture the last integrator one clock after the wrap, i.e. its
  // post-update value, before the next sample changes it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        r_cap[c] <= {ACC_WIDTH{1'b0}};
      end
    end else if (en_i && r_stb[0]) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        r_cap[c] <= r_int[c][STAGES-1];
      end
    end
  end

  // Comb k is fed by the capture register (k=0) or by comb k-1.
  always_comb begin
    for (int c = 0; c < IQ_NUM; c++) begin
      w_comb_in[c][0] = r_cap[c];
      for (int k = 1; k < STAGES; k++) begin
        w_comb_in[c][k] = r_comb[c][k-1];
      end
    end
  end

  // Comb stages: out = in - in delayed by DIFF_DELAY strobes. Each stage only
  // moves when its own strobe bit is set, so in-flight samples never mix.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          r_comb[c][k] <= {ACC_WIDTH{1'b0}};
          for (int m = 0; m < DIFF_DELAY; m++) begin
            r_dly[c][k][m] <= {ACC_WIDTH{1'b0}};
          end
        end
      end
    end else if (en_i) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        for (int k = 0; k < STAGES; k++) begin
          if (r_stb[k+1]) begin
            r_comb[c][k]   <= w_comb_in[c][k] - r_dly[c][k][DIFF_DELAY-1];
            r_dly[c][k][0] <= w_comb_in[c][k];
            for (int m = 1; m < DIFF_DELAY; m++) begin
              r_dly[c][k][m] <= r_dly[c][k][m-1];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [IQ_NUM-1:0][DATA_WIDTH-1:0] r_dout;
  logic                              r_tvalid;

`ifdef CIC_ROUND_EN
  logic [DATA_WIDTH-1:0] r_rnd [IQ_NUM];

  // Extra register stage holding the rounded, saturated sample.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        r_rnd[c] <= {DATA_WIDTH{1'b0}};
      end
    end else if (en_i && r_stb[STAGES+1]) begin
      for (int c = 0; c < IQ_NUM; c++) begin
        r_rnd[c] <= round_sat(r_comb[c][STAGES-1]);
      end
    end
  end
`endif

  // Output register: data held between pulses; valid is a one-cycle pulse
  // and is forced low while the block is disabled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_dout   <= '0;
      r_tvalid <= 1'b0;
    end else if (!en_i) begin
      r_tvalid <= 1'b0;
    end else begin
      r_tvalid <= r_stb[PIPE-1];
      if (r_stb[PIPE-1]) begin
        for (int c = 0; c < IQ_NUM; c++) begin
`ifdef CIC_ROUND_EN
          r_dout[c] <= r_rnd[c];
`else
          r_dout[c] <= r_comb[c][STAGES-1][ACC_WIDTH-1 -: DATA_WIDTH];
`endif
        end
      end
    end
  end

  assign tvalid_o = r_tvalid;
  assign tdata_o  = r_dout;

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Directed self-checking bench for cic_decimator with default parameters
// (IQ_NUM=2, DATA_WIDTH=16, STAGES=3, MAX_DECIM=8, DIFF_DELAY=1, ACC_WIDTH=25).
// Expected sequences below are hand-derived from the pipelined CIC equations:
// the last integrator after sample n is
//   DC A:      A*(n-1)*n*(n+1)/6
//   impulse A: A*n*(n-1)/2
// This is followed by three first differences of the values captured at the
// wrap samples, and then by >>9 (floor), or by +256 then >>9 when
// CIC_ROUND_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_decimator;

  localparam int IQ_NUM     = 2;
  localparam int DATA_WIDTH = 16;
  localparam int STAGES     = 3;
  localparam int MAX_DECIM  = 8;
  localparam int DIFF_DELAY = 1;
  localparam int RW         = $clog2(MAX_DECIM) + 1;
`ifdef CIC_ROUND_EN
  localparam int LAT = STAGES + 3;
`else
  localparam int LAT = STAGES + 2;
`endif
  localparam int NONE = -1000000;

  logic                              clk_i = 1'b0;
  logic                              rstn_i;
  logic                              en_i;
  logic [RW-1:0]                     decim_i;
  logic                              tvalid_i;
  logic [IQ_NUM-1:0][DATA_WIDTH-1:0] tdata_i;
  logic                              tvalid_o;
  logic [IQ_NUM-1:0][DATA_WIDTH-1:0] tdata_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gate_viol = 0;
  logic en_at_edge = 1'b1;

  int out_i[$];
  int out_q[$];
  int out_cyc[$];
  int acc_cyc[$];
  int e_i[$];
  int e_q[$];

  cic_decimator #(
    .IQ_NUM     (IQ_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (STAGES),
    .MAX_DECIM  (MAX_DECIM),
    .DIFF_DELAY (DIFF_DELAY)
  ) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (en_i),
    .decim_i  (decim_i),
    .tvalid_i (tvalid_i),
    .tdata_i  (tdata_i),
    .tvalid_o (tvalid_o),
    .tdata_o  (tdata_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter and enable seen at each active edge.
  always @(posedge clk_i) begin
    cyc        <= cyc + 1;
    en_at_edge <= en_i;
  end

  // Output collector, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (tvalid_o === 1'b1) begin
      out_i.push_back($signed(tdata_o[0]));
      out_q.push_back($signed(tdata_o[1]));
      out_cyc.push_back(cyc);
      if (!en_at_edge) gate_viol <= gate_viol + 1;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    out_i.delete();
    out_q.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset(input int r);
    @(negedge clk_i);
    rstn_i   = 1'b0;
    en_i     = 1'b1;
    tvalid_i = 1'b0;
    tdata_i  = '0;
    decim_i  = RW'(r);
    repeat (3) @(negedge clk_i);
    clear_logs();
    rstn_i = 1'b1;
  endtask

  task automatic send(input int n, input int vi, input int vq);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      tvalid_i   = 1'b1;
      tdata_i[0] = vi[DATA_WIDTH-1:0];
      tdata_i[1] = vq[DATA_WIDTH-1:0];
      if (en_i) acc_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      tvalid_i = 1'b0;
      tdata_i  = '0;
    end
  endtask

  // Compare the collected outputs (from index 'first') against e_i / e_q.
  task automatic check_outs(input string tag, input int first);
    check({tag, "_cnt"}, out_i.size(), e_i.size());
    for (int j = first; j < e_i.size(); j++) begin
      check($sformatf("%s_i%0d", tag, j), (j < out_i.size()) ? out_i[j] : NONE, e_i[j]);
      check($sformatf("%s_q%0d", tag, j), (j < out_q.size()) ? out_q[j] : NONE, e_q[j]);
    end
  endtask

  function automatic int lat_of(input int j);
    return (j < out_cyc.size()) ? out_cyc[j] : NONE;
  endfunction

  function automatic int acc_at(input int n);
    return (n < acc_cyc.size()) ? acc_cyc[n] + LAT : -NONE;
  endfunction

  initial begin
    rstn_i   = 1'b0;
    en_i     = 1'b1;
    decim_i  = RW'(8);
    tvalid_i = 1'b0;
    tdata_i  = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_valid", tvalid_o, 0);
    check("rst_data_i", $signed(tdata_o[0]), 0);
    check("rst_data_q", $signed(tdata_o[1]), 0);

    // DC settle: +100 at R=8
    do_reset(8);
    send(48, 100, 100);
    idle(12);
`ifdef CIC_ROUND_EN
    e_i = '{11, 77, 100, 100, 100, 100};
`else
    e_i = '{10, 76, 100, 100, 100, 100};
`endif
    e_q = e_i;
    check_outs("dc", 0);
    for (int j = 0; j < 6; j++) check($sformatf("dc_lat%0d", j), lat_of(j), acc_at(8*j + 7));

    // Full-scale DC: integrators wrap, steady output exact
    do_reset(8);
    send(64, 32767, -32768);
    idle(12);
    e_i = '{0, 0, 32767, 32767, 32767, 32767, 32767, 32767};
    e_q = '{0, 0, -32768, -32768, -32768, -32768, -32768, -32768};
    check_outs("fs", 2);

    // Impulse 16384 on I
    do_reset(8);
    send(1, 16384, 0);
    send(39, 0, 0);
    idle(12);
    e_i = '{672, 1344, 32, 0, 0};
    e_q = '{0, 0, 0, 0, 0};
    check_outs("imp", 0);
    check("imp_lat", lat_of(0), acc_at(7));

    // Ratio change 8 -> 4 mid-period, DC 100
    do_reset(8);
    send(3, 100, 100);
    decim_i = RW'(4);
    send(29, 100, 100);
    idle(12);
`ifdef CIC_ROUND_EN
    e_i = '{11, 10, 13, 13, 13, 13, 13};
`else
    e_i = '{10, 10, 13, 12, 12, 12, 12};
`endif
    e_q = e_i;
    check_outs("rc", 0);
    check("rc_lat0", lat_of(0), acc_at(7));
    check("rc_lat1", lat_of(1), acc_at(11));

    // Enable gating, decim_i=0 (treated as 8); gated inputs carry junk
    do_reset(0);
    send(8, 100, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      en_i       = 1'b0;
      tvalid_i   = 1'b1;
      tdata_i[0] = 16'sd30000;
      tdata_i[1] = 16'sd30000;
    end
    @(negedge clk_i);
    en_i     = 1'b1;
    tvalid_i = 1'b0;
    send(32, 100, 100);
    idle(12);
`ifdef CIC_ROUND_EN
    e_i = '{11, 77, 100, 100, 100};
`else
    e_i = '{10, 76, 100, 100, 100};
`endif
    e_q = e_i;
    check_outs("gate", 0);
    check("gate_valid_low", gate_viol, 0);

    // Asynchronous reset with a strobe in flight
    do_reset(8);
    send(16, 100, 100);
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_valid", tvalid_o, 0);
    check("arst_data_i", $signed(tdata_o[0]), 0);
    check("arst_data_q", $signed(tdata_o[1]), 0);
    clear_logs();
    idle(6);
    check("arst_nopulse", out_cyc.size(), 0);
    rstn_i = 1'b1;
    send(24, 100, 100);
    idle(12);
`ifdef CIC_ROUND_EN
    e_i = '{11, 77, 100};
`else
    e_i = '{10, 76, 100};
`endif
    e_q = e_i;
    check_outs("arst", 0);

    // Rounding: R=4, DC -1
    do_reset(4);
    send(32, -1, -1);
    idle(12);
`ifdef CIC_ROUND_EN
    e_i = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    e_i = '{-1, -1, -1, -1, -1, -1, -1, -1};
`endif
    e_q = e_i;
    check_outs("rnd", 0);

    // R=1: one output per accepted input, back to back
    do_reset(1);
    send(1, 16384, 0);
    send(7, 0, 0);
    idle(12);
    e_i = '{0, 0, 32, 0, 0, 0, 0, 0};
    e_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_outs("r1", 0);
    for (int j = 1; j < 8; j++) check($sformatf("r1_gap%0d", j), lat_of(j) - lat_of(j - 1), 1);
    check("r1_lat", lat_of(0), acc_at(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
